// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data load/store.
// Data side has priority, the request is held until mem_ack_i, and a timeout flags a dead memory.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TMO_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_e              state_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    tmo_d;
    logic                tmo_fire;
    logic [DATA_W-1:0]   rsp_data;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_data_q;
    logic                if_ack_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                dm_ack_q;
    logic                err_q;

    // Saturating timeout count; fires when this cycle would reach all-ones without an ack.
    always_comb begin
        tmo_d    = (tmo_q == TMO_MAX) ? TMO_MAX : tmo_q + TMO_W'(1);
        tmo_fire = ~mem_ack_i & (tmo_d == TMO_MAX);
        rsp_data = mem_ack_i ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            if_ack_q    <= 1'b0;
            dm_rdata_q  <= '0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dm_req_i) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        tmo_q       <= '0;
                        state_q     <= GNT_D;
                    end else if (if_req_i) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        tmo_q       <= '0;
                        state_q     <= GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    if (!mem_ack_i) begin
                        tmo_q <= tmo_d;
                    end
                    if (mem_ack_i || tmo_fire) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= DONE;
                        if (!mem_ack_i) begin
                            err_q <= 1'b1;
                        end
                        if (state_q == GNT_I) begin
                            if_data_q <= rsp_data;
                            if_ack_q  <= 1'b1;
                        end else begin
                            dm_ack_q <= 1'b1;
                            // Stores leave the last load data untouched.
                            if (!mem_we_q) begin
                                dm_rdata_q <= rsp_data;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign if_ack_o    = if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign err_o       = err_q;

    // Pipeline freeze while either side still waits for its completion pulse.
    assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, store, timeout, reset abort, dropped request.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO_W  = 4;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_ack;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ack_o(if_ack),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .stall_o(stall), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({mem_req, mem_we, if_ack, dm_ack, err, stall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 000000", {mem_req, mem_we, if_ack, dm_ack, err, stall});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, if_data, dm_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, if_data, dm_rdata});
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h04;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0 got %b exp 1", stall); end
        tick();
        #1;
        n_tests++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h04}) begin
            n_fail++;
            $display("FAIL fetch_grant got req=%b we=%b addr=%h exp 1 0 00000004", mem_req, mem_we, mem_addr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h8C220000;
        #1;
        n_tests++;
        if ({stall, if_ack} !== 2'b10) begin n_fail++; $display("FAIL fetch_stall_c2 got %b exp 10", {stall, if_ack}); end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++;
        if ({if_ack, stall, mem_req, dm_ack} !== 4'b1000) begin
            n_fail++;
            $display("FAIL fetch_done got ack/stall/req/dmack=%b exp 1000", {if_ack, stall, mem_req, dm_ack});
        end
        n_tests++;
        if (if_data !== 32'h8C220000) begin n_fail++; $display("FAIL fetch_data got %h exp 8c220000", if_data); end
        if_req = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({if_ack, mem_req} !== 2'b00) begin n_fail++; $display("FAIL fetch_idle got %b exp 00", {if_ack, mem_req}); end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h08;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        tick();
        #1;
        n_tests++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
            n_fail++;
            $display("FAIL prio_first got req=%b we=%b addr=%h exp 1 0 00000040", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++;
        if ({dm_ack, if_ack, dm_rdata} !== {2'b10, 32'h1234}) begin
            n_fail++;
            $display("FAIL prio_dm_done got dmack=%b ifack=%b rdata=%h exp 1 0 00001234", dm_ack, if_ack, dm_rdata);
        end
        dm_req = 1'b0;
        tick();
        tick();
        #1;
        n_tests++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h08}) begin
            n_fail++;
            $display("FAIL prio_second got req=%b we=%b addr=%h exp 1 0 00000008", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++;
        if ({if_ack, dm_ack, if_data} !== {2'b10, 32'h11112222}) begin
            n_fail++;
            $display("FAIL prio_if_done got ifack=%b dmack=%b data=%h exp 1 0 11112222", if_ack, dm_ack, if_data);
        end
        if_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF;
        tick();
        dm_addr = 32'h99; dm_wdata = 32'h0BADF00D; dm_we = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) begin mem_ack = 1'b1; mem_rdata = 32'hFFFF0000; end
            #1;
            n_tests++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, dm_ack} !== {2'b11, 32'h10, 32'hDEADBEEF, 1'b0}) begin
                n_fail++;
                $display("FAIL store_hold c%0d got req=%b we=%b addr=%h wdata=%h ack=%b", c, mem_req, mem_we, mem_addr, mem_wdata, dm_ack);
            end
            tick();
        end
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++;
        if ({dm_ack, mem_req, dm_rdata} !== {2'b10, 32'h1234}) begin
            n_fail++;
            $display("FAIL store_done got ack=%b req=%b rdata=%h exp 1 0 00001234", dm_ack, mem_req, dm_rdata);
        end
        dm_req = 1'b0;
        tick();
        n_tests++;
        if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL store_ack_pulse got %b exp 0", dm_ack); end
        tick();
    endtask

    task automatic test_drop_req();
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        if_req = 1'b0;
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        #1;
        n_tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h20}) begin
            n_fail++;
            $display("FAIL drop_hold got req=%b addr=%h exp 1 00000020", mem_req, mem_addr);
        end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++;
        if ({if_ack, if_data} !== {1'b1, 32'hCAFE0001}) begin
            n_fail++;
            $display("FAIL drop_done got ack=%b data=%h exp 1 cafe0001", if_ack, if_data);
        end
        tick();
        tick();
        n_tests++;
        if ({if_ack, mem_req} !== 2'b00) begin n_fail++; $display("FAIL drop_no_regrant got %b exp 00", {if_ack, mem_req}); end
    endtask

    task automatic test_reset_mid();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5555;
        #1;
        n_tests++;
        if ({mem_req, dm_ack, mem_addr, dm_rdata, if_data} !== 99'h0) begin
            n_fail++;
            $display("FAIL rstmid_clear got req=%b ack=%b addr=%h rdata=%h", mem_req, dm_ack, mem_addr, dm_rdata);
        end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++;
        if ({dm_ack, mem_req, dm_rdata, err} !== 35'h0) begin
            n_fail++;
            $display("FAIL rstmid_ignore got ack=%b req=%b rdata=%h err=%b", dm_ack, mem_req, dm_rdata, err);
        end
        tick();
    endtask

    task automatic test_tmo_ack_wins();
        if_req = 1'b1; if_addr = 32'h28;
        tick();
        for (int c = 1; c < 15; c++) tick();
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        n_tests++;
        if ({if_ack, err, if_data} !== {2'b10, 32'h77}) begin
            n_fail++;
            $display("FAIL tmo_ack_wins got ack=%b err=%b data=%h exp 1 0 00000077", if_ack, err, if_data);
        end
        if_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        if_req = 1'b1; if_addr = 32'h30;
        tick();
        for (int c = 1; c <= 15; c++) begin
            #1;
            n_tests++;
            if ({mem_req, err, if_ack} !== 3'b100) begin
                n_fail++;
                $display("FAIL tmo_wait c%0d got req/err/ack=%b exp 100", c, {mem_req, err, if_ack});
            end
            tick();
        end
        #1;
        n_tests++;
        if ({if_ack, err, mem_req, if_data} !== {3'b110, 32'h0}) begin
            n_fail++;
            $display("FAIL tmo_fire got ack=%b err=%b req=%b data=%h exp 1 1 0 0", if_ack, err, mem_req, if_data);
        end
        if_req = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        n_tests++;
        if ({err, if_ack} !== 2'b10) begin n_fail++; $display("FAIL tmo_sticky got %b exp 10", {err, if_ack}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_rst_clear got %b exp 0", err); end
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        test_reset();
        test_single_fetch();
        test_priority();
        test_store();
        test_drop_req();
        test_reset_mid();
        test_tmo_ack_wins();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
